// File: rtl/mips_dmem_mmio.sv
// Data memory for the single-cycle MIPS core: word RAM plus MMIO cycle counter, TX FIFO and 8N1 UART.
// Optional LED register at IO offset 3 is built when DMEM_LED_EN is defined.
module mips_dmem_mmio #(
   parameter int DEPTH_WORDS = 64,
   parameter int CLK_DIV     = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        tx,
   output logic [7:0]  led
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int DW = $clog2(CLK_DIV);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];
   state_t        state_q, state_d;
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   cycle_q, cycle_d;
   logic [31:0]   led_rd;

   logic          ram_sel, io_sel, busy, full, empty, div_end;
   logic          push_req, push_ok, pop, clr_ovf;
   logic [1:0]    off;
   logic [AW-1:0] ram_idx;
   logic [31:0]   status;
   logic          unused_addr;

   assign unused_addr = ^addr[1:0];
   assign ram_sel = ~addr[31];
   assign io_sel  = (addr[31:4] == 28'hFFFF000);
   assign off     = addr[3:2];
   assign ram_idx = addr[AW+1:2];

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PW{1'b0}}});
   assign div_end = (div_cnt_q == DW'(CLK_DIV - 1));

   // Pop at the end of a stop bit too, so queued frames run back to back.
   assign pop      = ((state_q == S_IDLE) || (state_q == S_STOP && div_end)) && !empty;
   assign push_req = memwrite && io_sel && (off == 2'd1);
   assign push_ok  = push_req && (!full || pop);
   assign clr_ovf  = memwrite && io_sel && (off == 2'd2) && writedata[3];
   assign status   = {28'b0, ovf_q, empty, full, busy};

`ifdef DMEM_LED_EN
   logic [7:0] led_q, led_d;
   always_comb begin
      led_d = led_q;
      if (memwrite && io_sel && off == 2'd3) led_d = writedata[7:0];
   end
   always_ff @(posedge clk) begin
      if (reset) led_q <= 8'h00;
      else       led_q <= led_d;
   end
   assign led    = led_q;
   assign led_rd = {24'b0, led_q};
`else
   assign led    = 8'h00;
   assign led_rd = 32'b0;
`endif

   always_comb begin
      readdata = 32'b0;
      if (ram_sel) readdata = mem_q[ram_idx];
      else if (io_sel) begin
         case (off)
            2'd0:    readdata = cycle_q;
            2'd2:    readdata = status;
            2'd3:    readdata = led_rd;
            default: readdata = 32'b0;
         endcase
      end
   end

   always_comb begin
      cycle_d  = cycle_q + 32'd1;
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
      ovf_d    = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (push_req && !push_ok) ovf_d = 1'b1;
   end

   // UART next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!empty) state_d = S_START;
         S_START: if (div_end) state_d = S_DATA;
         S_DATA:  if (div_end && bit_cnt_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (div_end) state_d = empty ? S_IDLE : S_START;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_cnt_d = (state_q == S_IDLE || div_end) ? '0 : div_cnt_q + DW'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      if (state_q == S_START) bit_cnt_d = 3'd0;
      else if (state_q == S_DATA && div_end) bit_cnt_d = bit_cnt_q + 3'd1;
      if (pop) shift_d = fifo_q[rd_ptr_q[PW-1:0]];
      else if (state_q == S_DATA && div_end) shift_d = {1'b0, shift_q[7:1]};
   end

   // UART outputs
   always_comb begin
      tx   = 1'b1;
      busy = 1'b1;
      case (state_q)
         S_IDLE:  busy = 1'b0;
         S_START: tx = 1'b0;
         S_DATA:  tx = shift_q[0];
         default: tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         cycle_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
         cycle_q   <= cycle_d;
      end
   end

   always_ff @(posedge clk) begin
      if (memwrite && ram_sel) mem_q[ram_idx] <= writedata;
      if (push_ok) fifo_q[wr_ptr_q[PW-1:0]] <= writedata[7:0];
   end
endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Bench for mips_dmem_mmio: directed scenarios plus random traffic against a frame-level reference model.
module tb_mips_dmem_mmio;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int CD    = 16;
   localparam int FD    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] writedata = 32'h0;
   logic [31:0] readdata;
   logic        tx;
   logic [7:0]  led;

   mips_dmem_mmio #(.DEPTH_WORDS(DEPTH), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
      .writedata(writedata), .readdata(readdata), .tx(tx), .led(led)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model: RAM image, byte queue, and position inside the current frame.
   logic [31:0] mem_m [DEPTH];
   bit          wr_m [DEPTH];
   logic [7:0]  q_m [$];
   logic [7:0]  cur_m = 8'h00;
   int          ft_m = -1;
   bit          ovf_m = 1'b0;
   logic [31:0] cyc_m = 32'h0;
   logic [7:0]  led_m = 8'h00;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin : model
      int psize;
      bit fend, popn, io;
      logic [1:0] o;
      if (reset) begin
         q_m.delete();
         ft_m  = -1;
         ovf_m = 1'b0;
         cyc_m = 32'h0;
         led_m = 8'h00;
      end else begin
         cyc_m = cyc_m + 32'd1;
         psize = q_m.size();
         fend  = (ft_m == 10*CD - 1);
         popn  = (ft_m < 0 || fend) && psize > 0;
         if (popn) begin
            cur_m = q_m.pop_front();
            ft_m  = 0;
         end else if (fend) ft_m = -1;
         else if (ft_m >= 0) ft_m++;
         io = (addr[31:4] == 28'hFFFF000);
         o  = addr[3:2];
         if (memwrite && !addr[31]) begin
            mem_m[addr[2 +: AW]] = writedata;
            wr_m[addr[2 +: AW]]  = 1'b1;
         end
         if (memwrite && io && o == 2'd1) begin
            if (psize < FD || popn) q_m.push_back(writedata[7:0]);
            else ovf_m = 1'b1;
         end
         if (memwrite && io && o == 2'd2 && writedata[3]) ovf_m = 1'b0;
`ifdef DMEM_LED_EN
         if (memwrite && io && o == 2'd3) led_m = writedata[7:0];
`endif
      end
   end

   function automatic logic exp_tx();
      int b;
      if (ft_m < 0) return 1'b1;
      b = ft_m / CD;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return cur_m[b-1];
   endfunction

   task automatic exp_rd(input logic [31:0] a, output logic [31:0] v, output bit known);
      known = 1'b1;
      v = 32'h0;
      if (!a[31]) begin
         known = wr_m[a[2 +: AW]];
         v = mem_m[a[2 +: AW]];
      end else if (a[31:4] == 28'hFFFF000) begin
         case (a[3:2])
            2'd0: v = cyc_m;
            2'd2: v = {28'b0, ovf_m, q_m.size() == 0, q_m.size() == FD, ft_m >= 0};
            2'd3: v = {24'b0, led_m};
            default: v = 32'h0;
         endcase
      end
   endtask

   logic [31:0] rd_s;
   logic        tx_s;
   int          nstep = 0;

   // One clock: drive, sample on the falling edge, then move past the rising edge.
   task automatic step(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] ev;
      bit kn;
      reset = rst; memwrite = we; addr = a; writedata = d;
      @(negedge clk);
      rd_s = readdata;
      tx_s = tx;
      nstep++;
      if (chk_en) begin
         exp_rd(a, ev, kn);
         if (kn) chk("rdata", rd_s, ev);
         chk("tx", {31'b0, tx_s}, {31'b0, exp_tx()});
         chk("led", {24'b0, led}, {24'b0, led_m});
      end
      @(posedge clk); #1;
   endtask

   localparam logic [31:0] A_CYC = 32'hFFFF0000;
   localparam logic [31:0] A_TXD = 32'hFFFF0004;
   localparam logic [31:0] A_STA = 32'hFFFF0008;
   localparam logic [31:0] A_LED = 32'hFFFF000C;

   initial begin
      logic [9:0] pat;
      int s0, idle_at, lows, r;
      logic [31:0] a;
      pat = 10'b1010000010;

      // reset state
      step(1, 0, A_STA, 0);
      chk_en = 1'b1;
      step(1, 0, A_STA, 0);
      chk("rst_status", rd_s, 32'h4);
      chk("rst_tx", {31'b0, tx_s}, 32'h1);
      step(1, 0, A_CYC, 0);
      chk("rst_cycle", rd_s, 32'h0);
      chk("rst_led", {24'b0, led}, 32'h0);

      // cycle counter and wrap
      for (int k = 0; k <= 100; k++) step(0, 0, A_CYC, 0);
      chk("cycle_100", rd_s, 32'd100);
      force dut.cycle_q = 32'hFFFF_FFFF;
      cyc_m = 32'hFFFF_FFFF;
      #1 release dut.cycle_q;
      step(0, 0, A_CYC, 0);
      chk("cycle_max", rd_s, 32'hFFFF_FFFF);
      step(0, 0, A_CYC, 0);
      chk("cycle_wrap", rd_s, 32'h0);

      // RAM and aliasing
      step(0, 1, 32'h10, 32'hDEADBEEF);
      step(0, 0, 32'h10, 0);
      chk("ram_rd", rd_s, 32'hDEADBEEF);
      step(0, 0, 32'h110, 0);
      chk("ram_alias", rd_s, 32'hDEADBEEF);
      step(0, 0, 32'h8000_0010, 0);
      chk("unmapped_rd", rd_s, 32'h0);

      // single frame of 0x41, sampled mid-bit
      step(0, 1, A_TXD, 32'h41);
      step(0, 0, A_STA, 0);
      chk("tx_before_pop", {31'b0, tx_s}, 32'h1);
      for (int t = 0; t < 10*CD; t++) begin
         step(0, 0, A_STA, 0);
         if (t % CD == CD/2) chk("frame_bit", {31'b0, tx_s}, {31'b0, pat[t/CD]});
         if (t == 5*CD) chk("busy_mid", {31'b0, rd_s[0]}, 32'h1);
      end
      step(0, 0, A_STA, 0);
      chk("status_after", rd_s, 32'h4);

      // overflow while busy, then back-to-back drain
      step(0, 1, A_TXD, 32'h5A);
      s0 = nstep;
      step(0, 0, A_STA, 0);
      for (int i = 0; i < 5; i++) step(0, 1, A_TXD, {24'b0, 8'($urandom)});
      step(0, 0, A_STA, 0);
      chk("full_ovf", rd_s, 32'hB);
      step(0, 1, A_STA, 32'h8);
      step(0, 0, A_STA, 0);
      chk("ovf_clr", rd_s, 32'h3);
      idle_at = -1;
      for (int i = 0; i < 1000 && idle_at < 0; i++) begin
         step(0, 0, A_STA, 0);
         if (rd_s[0] == 1'b0) idle_at = nstep;
      end
      chk("drain_end", idle_at, s0 + 2 + 5*10*CD);

      // reset mid-frame
      step(0, 1, A_TXD, 32'h00);
      step(0, 1, A_TXD, 32'h33);
      for (int i = 0; i < 40; i++) step(0, 0, A_STA, 0);
      step(1, 0, A_STA, 0);
      step(0, 0, A_STA, 0);
      chk("abort_tx", {31'b0, tx_s}, 32'h1);
      chk("abort_status", rd_s, 32'h4);
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         step(0, 0, A_STA, 0);
         if (tx_s !== 1'b1) lows++;
      end
      chk("abort_quiet", lows, 0);

      // LED register
      step(0, 1, A_LED, 32'h1A5);
      step(0, 0, A_LED, 0);
`ifdef DMEM_LED_EN
      chk("led_port", {24'b0, led}, 32'hA5);
      chk("led_rd", rd_s, 32'hA5);
`else
      chk("led_port", {24'b0, led}, 32'h0);
      chk("led_rd", rd_s, 32'h0);
`endif

      // random traffic
      for (int i = 0; i < 5000; i++) begin
         r = $urandom_range(0, 499);
         if (r == 0) step(1, 0, A_STA, 0);
         else if (r < 120) begin
            a = {1'b0, 21'($urandom), 10'($urandom_range(0, 1023))};
            step(0, r < 60, a, $urandom);
         end else if (r < 140) step(0, 1, A_TXD | 32'($urandom_range(0, 3)), $urandom);
         else if (r < 160) step(0, 1, A_STA, $urandom);
         else if (r < 180) step(0, 1, A_LED, $urandom);
         else if (r < 200) step(0, 1, A_CYC, $urandom);
         else if (r < 240) begin
            a = 32'h8000_0000 | $urandom;
            if (a[31:4] == 28'hFFFF000) a[20] = 1'b0;
            step(0, $urandom_range(0, 1) == 1, a, $urandom);
         end else step(0, 0, A_CYC | 32'($urandom_range(0, 15)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
